// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for an asynchronous (dual-clock) FIFO.
//
// Owns the read pointer, and brings the write pointer into the read clock
// domain. From those it derives the empty flag, the almost-empty flag, the
// fill level and a sticky underflow flag.
//
// Pointers are ADDRSIZE+1 bits wide. The extra MSB tells "full" apart from
// "empty" when the address bits match. Only the read pointer's Gray form
// crosses to the write domain. The incoming Gray write pointer goes through a
// plain two-flop synchronizer. Because a Gray code changes one bit per step,
// the synchronized value is always either the old pointer or the new one.
//
// Every status output is registered from next-state values. This makes empty
// assert on the same edge that consumes the last entry. Empty only clears
// after the new write pointer has passed through the synchronizer, so the
// flag is pessimistic but always safe.

module fifo_rd_ctrl #(
   parameter int ADDRSIZE = 4,
   parameter int AE_LEVEL = 1
) (
   input  logic                rclk,
   input  logic                rrst_n,
   input  logic [ADDRSIZE:0]   wptr,
   input  logic                rinc,
   input  logic                rclr_err,
   output logic [ADDRSIZE-1:0] raddr,
   output logic [ADDRSIZE:0]   rptr,
   output logic                rempty,
   output logic                raempty,
   output logic [ADDRSIZE:0]   rlevel,
   output logic                runderflow
);

   // Almost-empty threshold, resized once to pointer width for the compare.
   localparam logic [ADDRSIZE:0] AE_THRESH = (ADDRSIZE+1)'(AE_LEVEL);

   // Two-stage synchronizer for the foreign Gray write pointer.
   logic [ADDRSIZE:0] rq1_wptr;
   logic [ADDRSIZE:0] rq2_wptr;

   // Binary read pointer and its next-state companions.
   logic [ADDRSIZE:0] rbin;
   logic [ADDRSIZE:0] rbin_next;
   logic [ADDRSIZE:0] rgray_next;
   logic              rd_en;

   // Synchronized write pointer converted to binary, and the resulting level.
   logic [ADDRSIZE:0] wbin_s;
   logic [ADDRSIZE:0] level_next;

   // Capture the Gray write pointer through two flops. Only rq2_wptr is used.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rq1_wptr <= '0;
         rq2_wptr <= '0;
      end else begin
         rq1_wptr <= wptr;
         rq2_wptr <= rq1_wptr;
      end
   end

   // A read happens only when one is requested and the FIFO is not empty.
   // The pointer therefore stays put when a read is attempted while empty.
   always_comb begin
      rd_en      = rinc & ~rempty;
      rbin_next  = rbin + {{ADDRSIZE{1'b0}}, rd_en};
      rgray_next = (rbin_next >> 1) ^ rbin_next;
   end

   // Convert Gray to binary. Binary bit i is the XOR of Gray bits i and above.
   always_comb begin
      wbin_s = '0;
      for (int i = 0; i <= ADDRSIZE; i++) begin
         wbin_s[i] = ^(rq2_wptr >> i);
      end
   end

   // Fill level seen after this edge. The subtraction wraps modulo
   // 2^(ADDRSIZE+1), so it stays correct across pointer wrap. Pointers that
   // differ only in the MSB give exactly 2^ADDRSIZE, the full count.
   always_comb begin
      level_next = wbin_s - rbin_next;
   end

   // Read pointer register. Its low bits address memory with no path from rinc.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin <= '0;
         rptr <= '0;
      end else begin
         rbin <= rbin_next;
         rptr <= rgray_next;
      end
   end

   assign raddr = rbin[ADDRSIZE-1:0];

   // Register empty, almost-empty and level from the same next-state values.
   // This keeps empty true exactly when the level reads zero.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rempty  <= 1'b1;
         raempty <= 1'b1;
         rlevel  <= '0;
      end else begin
         rempty  <= (rgray_next == rq2_wptr);
         raempty <= (level_next <= AE_THRESH);
         rlevel  <= level_next;
      end
   end

   // Sticky underflow. A read attempt while empty sets it; rclr_err clears it.
   // If both happen in the same cycle, set wins.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         runderflow <= 1'b0;
      end else if (rinc & rempty) begin
         runderflow <= 1'b1;
      end else if (rclr_err) begin
         runderflow <= 1'b0;
      end
   end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, meaning FIFO depth is 2^ADDRSIZE entries.
REQ-002 SHALL have parameter AE_LEVEL, default 1, meaning the almost-empty threshold in entries; legal range 0 to 2^ADDRSIZE-1.
REQ-003 SHALL have port rclk, input, 1, read-domain clock; this is the block's only clock.
REQ-004 SHALL have port rrst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port wptr, input, ADDRSIZE+1, Gray-coded write pointer from the write clock domain, asynchronous to rclk.
REQ-006 SHALL have port rinc, input, 1, read request for one entry this cycle.
REQ-007 SHALL have port rclr_err, input, 1, clears the sticky underflow flag.
REQ-008 SHALL have port raddr, output, ADDRSIZE, read address to the external dual-port memory.
REQ-009 SHALL have port rptr, output, ADDRSIZE+1, registered Gray read pointer for the write-domain synchronizer.
REQ-010 SHALL have port rempty, output, 1, FIFO empty.
REQ-011 SHALL have port raempty, output, 1, almost empty.
REQ-012 SHALL have port rlevel, output, ADDRSIZE+1, read-side fill level, range 0 to 2^ADDRSIZE.
REQ-013 SHALL have port runderflow, output, 1, sticky error flag: a read was attempted while empty.

Function
REQ-014 SHALL synchronize wptr through two rclk flops (rq1_wptr, then rq2_wptr) and use only rq2_wptr in any logic.
REQ-015 SHALL hold a binary read pointer rbin of ADDRSIZE+1 bits, with rbin_next = rbin + (rinc & ~rempty), modulo 2^(ADDRSIZE+1).
REQ-016 SHALL compute rgray_next = (rbin_next >> 1) ^ rbin_next and register it as rptr, so that rptr changes at most one bit per clock.
REQ-017 SHALL drive raddr = rbin[ADDRSIZE-1:0] directly from the register, with no combinational path from rinc.
REQ-018 SHALL register rempty <= (rgray_next == rq2_wptr).
REQ-019 SHALL convert rq2_wptr from Gray to binary (wbin_s) and register rlevel <= wbin_s - rbin_next, modulo 2^(ADDRSIZE+1).
REQ-020 SHALL register raempty <= (wbin_s - rbin_next) <= AE_LEVEL.
REQ-021 SHALL keep rempty==1 exactly when rlevel==0 in every cycle, since both are derived from the same next-state values.
REQ-022 SHALL ignore rinc while rempty==1: rbin, rptr and raddr stay unchanged.
REQ-023 SHALL set runderflow on any cycle with rinc & rempty, and SHALL clear it on rclr_err; set wins when both occur in the same cycle.
REQ-024 SHALL show latency from a stable wptr change to rempty/rlevel update of three rclk rising edges (sync, sync, register).
REQ-025 SHALL deassert empty pessimistically only (stale synchronized wptr); it SHALL assert empty immediately on the clock edge that consumes the last entry.
REQ-026 SHALL wrap rbin from 2^(ADDRSIZE+1)-1 to 0; the Gray wrap SHALL be a single MSB change; rlevel arithmetic SHALL stay correct across the wrap.
REQ-027 SHALL report rlevel=2^ADDRSIZE when the pointers differ only in the MSB (full).

Reset
REQ-028 SHALL, while rrst_n==0, asynchronously force rq1_wptr=0, rq2_wptr=0, rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0, runderflow=0.
REQ-029 SHALL, when rrst_n asserts mid-operation, discard any in-progress read and SHALL NOT require a clock edge to reach reset values.
REQ-030 SHALL rely on rrst_n deassertion being synchronous to rclk, provided externally.

Verification (ADDRSIZE=4, AE_LEVEL=1)
REQ-031 SHALL cover reset: apply rrst_n=0 with no clock -> rempty=1, raempty=1, rlevel=0, rptr=5'b00000, raddr=0, runderflow=0.
REQ-032 SHALL cover wptr step: step wptr to gray(3)=5'b00010 and hold -> rempty falls on the 3rd rclk edge, rlevel=3, raempty=0.
REQ-033 SHALL cover draining: hold rinc=1 for 3 cycles -> raddr sequence 0,1,2; rlevel sequence 2,1,0; raempty=1 at level 1; rempty=1 after the 3rd read; rptr=5'b00010.
REQ-034 SHALL cover underflow: rinc=1 while empty -> rbin unchanged and runderflow=1 held; assert rinc & rempty together with rclr_err -> runderflow stays 1; rclr_err alone -> 0.
REQ-035 SHALL cover wrap and full: set rbin=30 with wptr=gray(14)=5'b01001 -> rlevel=16; read 2 -> rbin=0, rptr=5'b00000, rlevel=14.
REQ-036 SHALL cover reset mid-read: drop rrst_n between rclk edges with rlevel=5 -> all outputs at reset values immediately; reads resume from raddr=0 after release.
